// File: rtl/vfu_result_arbiter.sv
// Lane write-back arbiter: grants ALU/MFPU result writes per VRF bank with
// per-bank round-robin priority and registers a banked VRF write port.
module vfu_result_arbiter #(
    parameter int unsigned NrBanks    = 8,
    parameter int unsigned NrVInsn    = 8,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned VAddrWidth = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  alu_result_req_i,
    input  logic [$clog2(NrVInsn)-1:0]            alu_result_id_i,
    input  logic [VAddrWidth-1:0]                 alu_result_addr_i,
    input  logic [DataWidth-1:0]                  alu_result_wdata_i,
    input  logic [DataWidth/8-1:0]                alu_result_be_i,
    output logic                                  alu_result_gnt_o,
    input  logic                                  mfpu_result_req_i,
    input  logic [$clog2(NrVInsn)-1:0]            mfpu_result_id_i,
    input  logic [VAddrWidth-1:0]                 mfpu_result_addr_i,
    input  logic [DataWidth-1:0]                  mfpu_result_wdata_i,
    input  logic [DataWidth/8-1:0]                mfpu_result_be_i,
    output logic                                  mfpu_result_gnt_o,
    input  logic [NrBanks-1:0]                    bank_block_i,
    output logic [NrBanks-1:0]                    vrf_req_o,
    output logic [NrBanks-1:0][VAddrWidth-1:0]    vrf_addr_o,
    output logic [NrBanks-1:0][DataWidth-1:0]     vrf_wdata_o,
    output logic [NrBanks-1:0][DataWidth/8-1:0]   vrf_be_o,
    output logic [NrVInsn-1:0]                    write_done_o
);

    localparam int unsigned BankBits = $clog2(NrBanks);

    logic [NrBanks-1:0]    prio_q, prio_d;
    logic [BankBits-1:0]   alu_bank, mfpu_bank;
    logic [VAddrWidth-1:0] alu_row, mfpu_row;
    logic                  alu_ok, mfpu_ok, conflict;
    logic                  alu_gnt, mfpu_gnt;
    logic [NrBanks-1:0]    req_d;
    logic [NrVInsn-1:0]    done_d;

    assign alu_bank  = alu_result_addr_i[BankBits-1:0];
    assign mfpu_bank = mfpu_result_addr_i[BankBits-1:0];
    assign alu_row   = alu_result_addr_i >> BankBits;
    assign mfpu_row  = mfpu_result_addr_i >> BankBits;

    // prio_q[bank] = 0 favours the ALU, 1 favours the MFPU.
    always_comb begin
        alu_ok   = rst_ni && alu_result_req_i  && !bank_block_i[alu_bank];
        mfpu_ok  = rst_ni && mfpu_result_req_i && !bank_block_i[mfpu_bank];
        conflict = alu_ok && mfpu_ok && (alu_bank == mfpu_bank);
        alu_gnt  = alu_ok  && !(conflict &&  prio_q[alu_bank]);
        mfpu_gnt = mfpu_ok && !(conflict && !prio_q[mfpu_bank]);

        prio_d = prio_q;
        if (conflict) prio_d[alu_bank] = ~prio_q[alu_bank];

        req_d  = '0;
        done_d = '0;
        if (alu_gnt) begin
            req_d[alu_bank]         = 1'b1;
            done_d[alu_result_id_i] = 1'b1;
        end
        if (mfpu_gnt) begin
            req_d[mfpu_bank]         = 1'b1;
            done_d[mfpu_result_id_i] = 1'b1;
        end
    end

    assign alu_result_gnt_o  = alu_gnt;
    assign mfpu_result_gnt_o = mfpu_gnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q       <= '0;
            vrf_req_o    <= '0;
            vrf_addr_o   <= '0;
            vrf_wdata_o  <= '0;
            vrf_be_o     <= '0;
            write_done_o <= '0;
        end else begin
            prio_q       <= prio_d;
            vrf_req_o    <= req_d;
            write_done_o <= done_d;
            for (int unsigned b = 0; b < NrBanks; b++) begin
                if (alu_gnt && alu_bank == BankBits'(b)) begin
                    vrf_addr_o[b]  <= alu_row;
                    vrf_wdata_o[b] <= alu_result_wdata_i;
                    vrf_be_o[b]    <= alu_result_be_i;
                end else if (mfpu_gnt && mfpu_bank == BankBits'(b)) begin
                    vrf_addr_o[b]  <= mfpu_row;
                    vrf_wdata_o[b] <= mfpu_result_wdata_i;
                    vrf_be_o[b]    <= mfpu_result_be_i;
                end
            end
        end
    end

endmodule
